// File: rtl/mips_pkg.sv
// Pipeline-wide register file constants.
// Shared by registerfile, the pipeline and the write-back arbiter.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back request bundle and register-file write port.
// Sources drive requests (master); the arbiter serves them (slave).
interface wb_port_arbiter_if
    import mips_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
);

    logic                       wb_en;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0]            req_ready;
    logic [REG_ADDR_W*NREQ-1:0] req_addr;
    logic [DATA_W*NREQ-1:0]     req_data;
    logic                       regWrite;
    logic [REG_ADDR_W-1:0]      rc;
    logic [DATA_W-1:0]          dc;
    logic [CNT_W-1:0]           contention_cnt;

    modport master (
        output wb_en, req_valid, req_addr, req_data,
        input  req_ready, regWrite, rc, dc, contention_cnt
    );

    modport slave (
        input  wb_en, req_valid, req_addr, req_data,
        output req_ready, regWrite, rc, dc, contention_cnt
    );

endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Stateless round-robin grant: first requester at or after ptr wins.
// Produces both a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan requesters starting at ptr with wrap; take the first valid one.
    always_comb begin
        logic found;
        int   j;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (en_i && !found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port among NREQ write-back sources.
// One grant per cycle, registered onto regWrite/rc/dc the next cycle.
module wb_port_arbiter
    import mips_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      ptr_d;
    logic [NREQ-1:0]       gnt;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  accept;
    logic                  contend;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] rc_q;
    logic [DATA_W-1:0]     dc_q;
    logic [CNT_W-1:0]      cnt_q;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i (bus.req_valid),
        .en_i  (bus.wb_en),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // No grant is visible while reset is held, so nothing is consumed.
    assign bus.req_ready = rst ? '0 : gnt;
    assign accept        = |gnt;

    // Mux the winner's address/data and the next round-robin pointer.
    always_comb begin
        sel_addr = bus.req_addr[REG_ADDR_W*int'(gnt_idx) +: REG_ADDR_W];
        sel_data = bus.req_data[DATA_W*int'(gnt_idx) +: DATA_W];
        ptr_d    = ptr_q;
        if (accept) begin
            if (int'(gnt_idx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    // Contention: two or more sources competing while enabled.
    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) begin
            n = n + int'(bus.req_valid[i]);
        end
        contend = bus.wb_en && (n >= 2);
    end

    // Write-port register; a write to $0 is consumed but not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q  <= 1'b0;
            rc_q  <= '0;
            dc_q  <= '0;
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (accept) begin
                we_q <= (sel_addr != REG_ZERO);
                rc_q <= sel_addr;
                dc_q <= sel_data;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    // Saturating contention counter for performance debug.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (contend && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.regWrite       = we_q;
    assign bus.rc             = rc_q;
    assign bus.dc             = dc_q;
    assign bus.contention_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios plus random
// traffic, two instances (16-bit and 4-bit counters) on shared stimulus.
module tb_wb_port_arbiter;
    import mips_pkg::*;

    localparam int N = 3;

    typedef struct packed {
        logic        we;
        logic [4:0]  rc;
        logic [31:0] dc;
        logic [15:0] c16;
        logic [3:0]  c4;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          wb_en;
    logic [N-1:0]  vld;
    logic [4:0]    cur_ad [N];
    logic [31:0]   cur_dt [N];
    logic [4:0]    nxt_ad [N];
    logic [31:0]   nxt_dt [N];
    logic [5*N-1:0]  ab;
    logic [32*N-1:0] db;

    wb_port_arbiter_if #(.NREQ(N), .CNT_W(16)) bus ();
    wb_port_arbiter_if #(.NREQ(N), .CNT_W(4))  bus_s ();

    always_comb begin
        ab = '0;
        db = '0;
        for (int i = 0; i < N; i++) begin
            ab[5*i +: 5]   = cur_ad[i];
            db[32*i +: 32] = cur_dt[i];
        end
    end

    assign bus.wb_en       = wb_en;
    assign bus.req_valid   = vld;
    assign bus.req_addr    = ab;
    assign bus.req_data    = db;
    assign bus_s.wb_en     = wb_en;
    assign bus_s.req_valid = vld;
    assign bus_s.req_addr  = ab;
    assign bus_s.req_data  = db;

    wb_port_arbiter #(.NREQ(N), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    wb_port_arbiter #(.NREQ(N), .CNT_W(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] q_rdy [$];
    exp_t         q_out [$];

    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_rc;
    logic [31:0] m_dc;
    int          m_c16;
    int          m_c4;
    int          last_g;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_we   = 1'b0;
        m_rc   = '0;
        m_dc   = '0;
        m_c16  = 0;
        m_c4   = 0;
        last_g = -1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a,
                           input logic [31:0] d);
        nxt_ad[i] = a;
        nxt_dt[i] = d;
    endtask

    // One cycle of stimulus; expected responses go into the queues.
    task automatic drive(input logic en, input logic [N-1:0] v);
        exp_t         e;
        logic [N-1:0] r;
        int           g;
        @(negedge clk);
        wb_en = en;
        vld   = v;
        for (int i = 0; i < N; i++) begin
            cur_ad[i] = nxt_ad[i];
            cur_dt[i] = nxt_dt[i];
        end
        g = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        q_rdy.push_back(r);
        if (en && $countones(v) >= 2) begin
            if (m_c16 < 65535) m_c16++;
            if (m_c4 < 15) m_c4++;
        end
        if (g >= 0) begin
            m_we  = (cur_ad[g] != 5'd0);
            m_rc  = cur_ad[g];
            m_dc  = cur_dt[g];
            m_ptr = (g + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        e.we  = m_we;
        e.rc  = m_rc;
        e.dc  = m_dc;
        e.c16 = 16'(m_c16);
        e.c4  = 4'(m_c4);
        q_out.push_back(e);
        last_g = g;
    endtask

    // Reset asserted mid-cycle while all sources request.
    task automatic do_reset();
        @(negedge clk);
        vld   = '1;
        wb_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", 64'(bus.req_ready), 0);
        chk("rst_ready_s", 64'(bus_s.req_ready), 0);
        chk("rst_we", 64'(bus.regWrite), 0);
        chk("rst_rc", 64'(bus.rc), 0);
        chk("rst_dc", 64'(bus.dc), 0);
        chk("rst_cnt", 64'(bus.contention_cnt), 0);
        chk("rst_cnt_s", 64'(bus_s.contention_cnt), 0);
        @(posedge clk);
        #1;
        chk("rst_hold_we", 64'(bus.regWrite), 0);
        chk("rst_hold_ready", 64'(bus.req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        vld = '0;
        model_reset();
    endtask

    // Monitor for the combinational grant.
    initial begin
        logic [N-1:0] r;
        forever begin
            @(negedge clk);
            #2;
            if (q_rdy.size() > 0) begin
                r = q_rdy.pop_front();
                chk("req_ready", 64'(bus.req_ready), 64'(r));
                chk("req_ready_s", 64'(bus_s.req_ready), 64'(r));
            end
        end
    end

    // Monitor for the registered write port and counters.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_out.size() > 0) begin
                e = q_out.pop_front();
                chk("regWrite", 64'(bus.regWrite), 64'(e.we));
                if (e.we) begin
                    chk("rc", 64'(bus.rc), 64'(e.rc));
                    chk("dc", 64'(bus.dc), 64'(e.dc));
                end
                chk("rc_hold_s", 64'(bus_s.rc), 64'(bus_s.regWrite ? e.rc : bus_s.rc));
                chk("regWrite_s", 64'(bus_s.regWrite), 64'(e.we));
                chk("cnt16", 64'(bus.contention_cnt), 64'(e.c16));
                chk("cnt4", 64'(bus_s.contention_cnt), 64'(e.c4));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] pend;
        logic         en;
        wb_en = 1'b0;
        vld   = '0;
        for (int i = 0; i < N; i++) begin
            cur_ad[i] = '0;
            cur_dt[i] = '0;
            nxt_ad[i] = '0;
            nxt_dt[i] = '0;
        end
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("init_we", 64'(bus.regWrite), 0);
        chk("init_rc", 64'(bus.rc), 0);
        chk("init_dc", 64'(bus.dc), 0);
        chk("init_cnt", 64'(bus.contention_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        do_reset();

        set_req(1, 5'd5, 32'hDEADBEEF);
        drive(1'b1, 3'b010);
        drive(1'b1, 3'b010);

        do_reset();
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        set_req(2, 5'd3, 32'h3333_0000);
        repeat (9) drive(1'b1, 3'b111);
        @(posedge clk);
        #3;
        chk("fair_cnt", 64'(bus.contention_cnt), 9);

        set_req(2, 5'd0, 32'h0000_1234);
        drive(1'b1, 3'b100);

        set_req(0, 5'd7, 32'h7777_7777);
        repeat (3) drive(1'b0, 3'b001);
        drive(1'b1, 3'b001);

        repeat (20) drive(1'b1, 3'b111);
        @(posedge clk);
        #3;
        chk("sat_cnt4", 64'(bus_s.contention_cnt), 15);

        do_reset();
        drive(1'b1, 3'b001);
        drive(1'b1, 3'b010);
        drive(1'b1, 3'b001);
        drive(1'b1, 3'b011);

        set_req(0, 5'd9, 32'hAAAA_AAAA);
        set_req(1, 5'd9, 32'hBBBB_BBBB);
        drive(1'b1, 3'b011);
        drive(1'b1, 3'b011);

        pend = '0;
        for (int it = 0; it < 300; it++) begin
            if (it == 150) begin
                do_reset();
                pend = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    if ($urandom_range(0, 3) == 0) nxt_ad[i] = 5'd0;
                    else nxt_ad[i] = 5'($urandom);
                    nxt_dt[i] = $urandom;
                end
            end
            en = ($urandom_range(0, 7) != 0);
            drive(en, pend);
            if (last_g >= 0) pend[last_g] = 1'b0;
        end

        repeat (2) @(negedge clk);
        chk("drain_rdy", 64'(q_rdy.size()), 0);
        chk("drain_out", 64'(q_out.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares the register file's single write port (regWrite/rc/dc) among NREQ write-back sources (ALU, load unit, multiply/divide unit). Each source presents a valid/ready write request; one request per cycle is granted, registered, and driven onto the register-file write port on the following cycle. The arbiter sits between the execute/memory stages and `registerfile`. It also keeps a saturating contention counter for performance debug.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- CNT_W, 16, width of contention counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- wb_en  input  1  global enable; 0 = grant nothing (pipeline freeze)
- req_valid  input  NREQ  per-requester write request
- req_ready  output  NREQ  per-requester grant/accept (combinational)
- req_addr  input  5*NREQ  destination register, slice i = [5*i+4:5*i]
- req_data  input  32*NREQ  write data, slice i = [32*i+31:32*i]
- regWrite  output  1  register-file write enable (registered)
- rc  output  5  register-file write address (registered)
- dc  output  32  register-file write data (registered)
- contention_cnt  output  CNT_W  cycles with ≥2 valid requests while wb_en=1, saturating

## Operation
- Handshake: request i is accepted on a rising edge when req_valid[i] & req_ready[i]. The requester holds valid/addr/data stable until accepted. At most one req_ready bit is high in any cycle.
- Grant: when wb_en=1, search from index ptr upward with wrap at NREQ-1→0. The first valid requester gets req_ready. If no requester is valid, or wb_en=0, req_ready is all zero.
- Pointer: after an accept by requester g, ptr ← (g+1) mod NREQ. With no accept, ptr holds.
- Output register on an accept by requester g:
  - rc ← req_addr[g], dc ← req_data[g].
  - regWrite ← 1 if req_addr[g]≠0, else 0. Writes to $0 are consumed but suppressed.
- Output register with no accept: regWrite ← 0, and rc/dc hold their last values.
- contention_cnt increments when wb_en=1 and popcount(req_valid)≥2. It saturates at 2^CNT_W−1 and never wraps.
- Reset (asynchronous, any time, including mid-request):
  - regWrite=0, rc=0, dc=0, ptr=0, contention_cnt=0.
  - req_ready is forced to 0 while rst=1.
  - A request in flight at reset is dropped and must be re-presented by its source.

## Timing
- Request-to-write latency is 1 cycle: accepted at edge N, regWrite/rc/dc valid during cycle N+1, register file written at edge N+1.
- req_ready depends combinationally on req_valid, wb_en, and ptr. It must not depend on req_addr or req_data.
- Throughput is one write per cycle. With all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- Boundary behaviour:
  - A single valid requester is granted every cycle regardless of ptr.
  - Deassertion of wb_en takes effect in the same cycle: req_ready drops, and regWrite is 0 on the next cycle.
  - Back-to-back writes to the same rc from different requesters commit in grant order. The later write wins.
  - ptr = NREQ−1 with only requester 0 valid grants requester 0 (wrap-around).

## Structure
- Shared package `mips_pkg`: REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0. The package is shared with `registerfile` and the pipeline.
- Sub-module `rr_arbiter`: parameterised NREQ round-robin grant logic.
  - Inputs: req vector, enable, ptr.
  - Outputs: one-hot grant and encoded index.
  - Holds no state; ptr, the output register, and the counter live in `wb_port_arbiter`.
- Target size is roughly 150–250 lines total.

## Test plan
- Reset: assert rst mid-cycle with req_valid=3'b111 → req_ready=0 immediately; regWrite=0, rc=0, dc=0, contention_cnt=0. The first grant after release goes to requester 0.
- Single source: only req 1 valid with addr=5, data=32'hDEADBEEF → req_ready=3'b010 the same cycle; next cycle regWrite=1, rc=5, dc=32'hDEADBEEF.
- Fairness: all three valid for 9 cycles → grant order 0,1,2,0,1,2,0,1,2; contention_cnt=9.
- $0 suppression: req 2 writes addr=0, data=32'h1234 → req_ready[2]=1 and the request is accepted; next cycle regWrite=0.
- Freeze: wb_en=0 for 3 cycles with req 0 valid → req_ready=0 and regWrite=0 throughout, contention_cnt unchanged. On re-enable, req 0 is granted in the first cycle.
- Saturation/wrap: CNT_W=4 with 20 contention cycles → contention_cnt stops at 15. With ptr=2 and only req 0 valid → req 0 granted, ptr becomes 1.
